// File: rtl/hwpe_stream_fifo_bank_sched_pkg.sv
// Shared types for the banked multi-channel FIFO scheduler: per-channel queue
// controller states and the pop-side arbiter states.
package hwpe_stream_fifo_bank_sched_pkg;

    typedef enum logic [1:0] {
        FIFO_EMPTY  = 2'd0,
        FIFO_MIDDLE = 2'd1,
        FIFO_FULL   = 2'd2
    } fifo_state_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } sched_state_t;

    // Advance a ring pointer by one; power-of-2 depths wrap through truncation.
    function automatic logic [15:0] ptr_inc(input logic [15:0] ptr);
        return ptr + 16'd1;
    endfunction

endpackage

// File: rtl/hwpe_stream_fifo_bank_sched_ctrl.sv
// Queue controller for one virtual FIFO inside the shared bank: tracks
// EMPTY/MIDDLE/FULL and the push/pop pointers, with no occupancy counter.
module hwpe_stream_fifo_bank_sched_ctrl
    import hwpe_stream_fifo_bank_sched_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [PTR_W-1:0] push_ptr_o,
    output logic [PTR_W-1:0] pop_ptr_o
);

    fifo_state_t      state_d, state_q;
    logic [PTR_W-1:0] push_ptr_d, push_ptr_q;
    logic [PTR_W-1:0] pop_ptr_d, pop_ptr_q;
    logic             push_s, pop_s;

    // Next state: a push into FULL or a pop from EMPTY is ignored outright.
    always_comb begin
        push_s     = push_i & (state_q != FIFO_FULL);
        pop_s      = pop_i & (state_q != FIFO_EMPTY);
        push_ptr_d = push_s ? PTR_W'(ptr_inc(16'(push_ptr_q))) : push_ptr_q;
        pop_ptr_d  = pop_s ? PTR_W'(ptr_inc(16'(pop_ptr_q))) : pop_ptr_q;
        state_d    = state_q;
        case (state_q)
            FIFO_EMPTY: begin
                state_d = push_s ? FIFO_MIDDLE : FIFO_EMPTY;
            end
            FIFO_MIDDLE: begin
                if (push_s && !pop_s && (push_ptr_d == pop_ptr_q)) begin
                    state_d = FIFO_FULL;
                end else if (pop_s && !push_s && (pop_ptr_d == push_ptr_q)) begin
                    state_d = FIFO_EMPTY;
                end else begin
                    state_d = FIFO_MIDDLE;
                end
            end
            FIFO_FULL: begin
                state_d = pop_s ? FIFO_MIDDLE : FIFO_FULL;
            end
            default: begin
                state_d = FIFO_EMPTY;
            end
        endcase
    end

    // State and pointer registers; clear returns the channel to empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FIFO_EMPTY;
            push_ptr_q <= '0;
            pop_ptr_q  <= '0;
        end else if (clear_i) begin
            state_q    <= FIFO_EMPTY;
            push_ptr_q <= '0;
            pop_ptr_q  <= '0;
        end else begin
            state_q    <= state_d;
            push_ptr_q <= push_ptr_d;
            pop_ptr_q  <= pop_ptr_d;
        end
    end

    assign empty_o    = (state_q == FIFO_EMPTY);
    assign full_o     = (state_q == FIFO_FULL);
    assign push_ptr_o = push_ptr_q;
    assign pop_ptr_o  = pop_ptr_q;

endmodule

// File: rtl/hwpe_stream_fifo_bank_sched.sv
// NB_CHAN virtual FIFOs sharing one 1W/1R bank: produces bank addresses and
// enables, and round-robin schedules which non-empty channel drains.
module hwpe_stream_fifo_bank_sched
    import hwpe_stream_fifo_bank_sched_pkg::*;
#(
    parameter  int unsigned NB_CHAN    = 4,
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CHAN_W     = $clog2(NB_CHAN),
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned ADDR_W     = CHAN_W + PTR_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               push_valid_i,
    input  logic [CHAN_W-1:0]  push_chan_i,
    output logic               push_ready_o,
    output logic               pop_valid_o,
    output logic [CHAN_W-1:0]  pop_chan_o,
    input  logic               pop_ready_i,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_waddr_o,
    output logic [ADDR_W-1:0]  mem_raddr_o,
    output logic [NB_CHAN-1:0] empty_o,
    output logic [NB_CHAN-1:0] full_o
);

    typedef struct packed {
        logic [NB_CHAN-1:0]            empty;
        logic [NB_CHAN-1:0]            full;
        logic [NB_CHAN-1:0][PTR_W-1:0] push_ptr;
        logic [NB_CHAN-1:0][PTR_W-1:0] pop_ptr;
    } flags_fifo_bank_t;

    flags_fifo_bank_t              flags_s;
    logic [NB_CHAN-1:0]            empty_s, full_s;
    logic [NB_CHAN-1:0][PTR_W-1:0] push_ptr_s, pop_ptr_s;
    logic [NB_CHAN-1:0]            push_sel_s, pop_sel_s;
    logic [(1<<CHAN_W)-1:0]        full_pad_s;
    logic                          push_hs_s, pop_hs_s, any_s;
    logic [CHAN_W-1:0]             cand_s;

    sched_state_t                  sched_q;
    logic [CHAN_W-1:0]             rr_ptr_q, lock_chan_q;

    // First non-empty channel scanning upward from start, wrapping modulo NB_CHAN.
    function automatic logic [CHAN_W-1:0] rr_pick(input logic [NB_CHAN-1:0] empty,
                                                  input logic [CHAN_W-1:0]  start);
        logic [CHAN_W-1:0] idx;
        logic [CHAN_W-1:0] pick;
        logic              found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NB_CHAN; i++) begin
            idx = start + CHAN_W'(i);
            if (!found && !empty[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    for (genvar c = 0; c < NB_CHAN; c++) begin : gen_chan
        hwpe_stream_fifo_bank_sched_ctrl #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) i_ctrl (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i),
            .push_i     (push_sel_s[c]),
            .pop_i      (pop_sel_s[c]),
            .empty_o    (empty_s[c]),
            .full_o     (full_s[c]),
            .push_ptr_o (push_ptr_s[c]),
            .pop_ptr_o  (pop_ptr_s[c])
        );
    end

    assign flags_s.empty    = empty_s;
    assign flags_s.full     = full_s;
    assign flags_s.push_ptr = push_ptr_s;
    assign flags_s.pop_ptr  = pop_ptr_s;

    // Channel ids beyond NB_CHAN read as full so they are never accepted.
    always_comb begin
        full_pad_s                = '1;
        full_pad_s[NB_CHAN-1:0]   = flags_s.full;
    end

    assign push_ready_o = ~full_pad_s[push_chan_i];
    assign push_hs_s    = push_valid_i & push_ready_o & ~clear_i;
    assign mem_we_o     = push_hs_s;
    assign mem_waddr_o  = {push_chan_i, flags_s.push_ptr[push_chan_i]};

    assign any_s       = |(~flags_s.empty);
    assign cand_s      = rr_pick(flags_s.empty, rr_ptr_q);
    assign pop_valid_o = (sched_q == LOCKED) ? 1'b1 : any_s;
    assign pop_chan_o  = (sched_q == LOCKED) ? lock_chan_q : cand_s;
    assign pop_hs_s    = pop_valid_o & pop_ready_i & ~clear_i;
    assign mem_raddr_o = pop_valid_o ? {pop_chan_o, flags_s.pop_ptr[pop_chan_o]}
                                     : {ADDR_W{1'b0}};

    // Steer the two handshakes to the channel controllers they address.
    always_comb begin
        push_sel_s = '0;
        pop_sel_s  = '0;
        for (int c = 0; c < NB_CHAN; c++) begin
            push_sel_s[c] = push_hs_s & (push_chan_i == CHAN_W'(c));
            pop_sel_s[c]  = pop_hs_s & (pop_chan_o == CHAN_W'(c));
        end
    end

    // Pop arbiter: a stalled offer is frozen until accepted, then the
    // round-robin start moves just past the served channel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sched_q     <= UNLOCKED;
            rr_ptr_q    <= '0;
            lock_chan_q <= '0;
        end else if (clear_i) begin
            sched_q     <= UNLOCKED;
            rr_ptr_q    <= '0;
            lock_chan_q <= '0;
        end else begin
            case (sched_q)
                UNLOCKED: begin
                    if (pop_hs_s) begin
                        rr_ptr_q <= pop_chan_o + CHAN_W'(1);
                    end else if (pop_valid_o) begin
                        sched_q     <= LOCKED;
                        lock_chan_q <= cand_s;
                    end else begin
                        sched_q <= UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (pop_hs_s) begin
                        sched_q  <= UNLOCKED;
                        rr_ptr_q <= lock_chan_q + CHAN_W'(1);
                    end else begin
                        sched_q <= LOCKED;
                    end
                end
                default: begin
                    sched_q <= UNLOCKED;
                end
            endcase
        end
    end

    assign empty_o = flags_s.empty;
    assign full_o  = flags_s.full;

endmodule

// File: tb/tb_hwpe_stream_fifo_bank_sched.sv
// Randomised and directed bench for the banked FIFO scheduler, checked against
// a queue-based reference model of the channel contents and the arbiter policy.
module tb_hwpe_stream_fifo_bank_sched;

    localparam int NB_CHAN = 4;
    localparam int DEPTH   = 8;
    localparam int CHAN_W  = 2;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              push_valid_i = 1'b0;
    logic [CHAN_W-1:0] push_chan_i = '0;
    logic              push_ready_o;
    logic              pop_valid_o;
    logic [CHAN_W-1:0] pop_chan_o;
    logic              pop_ready_i = 1'b0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_waddr_o;
    logic [ADDR_W-1:0] mem_raddr_o;
    logic [NB_CHAN-1:0] empty_o;
    logic [NB_CHAN-1:0] full_o;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: each channel is a queue of the bank addresses it holds.
    int exp_q[NB_CHAN][$];
    int wcnt[NB_CHAN];
    int rr_start;
    int held;

    hwpe_stream_fifo_bank_sched #(
        .NB_CHAN    (NB_CHAN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .push_valid_i (push_valid_i),
        .push_chan_i  (push_chan_i),
        .push_ready_o (push_ready_o),
        .pop_valid_o  (pop_valid_o),
        .pop_chan_o   (pop_chan_o),
        .pop_ready_i  (pop_ready_i),
        .mem_we_o     (mem_we_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_raddr_o  (mem_raddr_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int c = 0; c < NB_CHAN; c++) begin
            exp_q[c].delete();
            wcnt[c] = 0;
        end
        rr_start = 0;
        held     = -1;
    endtask

    // Monitor: compare DUT outputs with the model mid-cycle, then commit the
    // handshakes the DUT will take at the coming edge.
    always @(negedge clk) begin
        logic [NB_CHAN-1:0] e_empty, e_full;
        logic               ev, e_ready, e_we, found;
        int                 ec, pc, waddr;
        if (!rst_ni) begin
            reset_model();
        end else begin
            e_empty = '0;
            e_full  = '0;
            for (int c = 0; c < NB_CHAN; c++) begin
                e_empty[c] = (exp_q[c].size() == 0);
                e_full[c]  = (exp_q[c].size() == DEPTH);
            end
            ev = 1'b0;
            ec = 0;
            if (held >= 0) begin
                ev = 1'b1;
                ec = held;
            end else begin
                found = 1'b0;
                for (int i = 0; i < NB_CHAN; i++) begin
                    if (!found && exp_q[(rr_start + i) % NB_CHAN].size() > 0) begin
                        found = 1'b1;
                        ec    = (rr_start + i) % NB_CHAN;
                    end
                end
                ev = found;
            end
            pc      = int'(push_chan_i);
            e_ready = (exp_q[pc].size() < DEPTH);
            e_we    = push_valid_i && e_ready && !clear_i;
            waddr   = pc * DEPTH + wcnt[pc];

            check("empty", 32'(empty_o), 32'(e_empty));
            check("full", 32'(full_o), 32'(e_full));
            check("push_ready", 32'(push_ready_o), 32'(e_ready));
            check("mem_we", 32'(mem_we_o), 32'(e_we));
            check("pop_valid", 32'(pop_valid_o), 32'(ev));
            if (e_we) check("mem_waddr", 32'(mem_waddr_o), 32'(waddr));
            if (ev) begin
                check("pop_chan", 32'(pop_chan_o), 32'(ec));
                check("mem_raddr", 32'(mem_raddr_o), 32'(exp_q[ec][0]));
            end else begin
                check("mem_raddr_idle", 32'(mem_raddr_o), 32'd0);
            end

            if (clear_i) begin
                reset_model();
            end else begin
                if (ev && pop_ready_i) begin
                    void'(exp_q[ec].pop_front());
                    rr_start = (ec + 1) % NB_CHAN;
                    held     = -1;
                end else if (ev) begin
                    held = ec;
                end
                if (e_we) begin
                    exp_q[pc].push_back(waddr);
                    wcnt[pc] = (wcnt[pc] + 1) % DEPTH;
                end
            end
        end
    end

    task automatic cyc(input logic pv, input int pc, input logic pr, input logic clr);
        @(posedge clk);
        #2;
        push_valid_i = pv;
        push_chan_i  = CHAN_W'(pc);
        pop_ready_i  = pr;
        clear_i      = clr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 32'(empty_o), 32'hF);
        check({tag, "_full"}, 32'(full_o), 32'h0);
        check({tag, "_pop_valid"}, 32'(pop_valid_o), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
        check({tag, "_push_ready"}, 32'(push_ready_o), 32'h1);
        check({tag, "_raddr"}, 32'(mem_raddr_o), 32'h0);
    endtask

    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_ni = 1'b1;

        // Three pushes to channel 2, then drain them.
        for (int i = 0; i < 3; i++) cyc(1'b1, 2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);

        // Fill channel 0, push while popping the full channel, then drain.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 0, 1'b0, 1'b0);
        cyc(1'b0, 1, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b0);
        cyc(1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 0, 1'b1, 1'b0);

        // Round robin across channels 0, 1 and 3.
        for (int r = 0; r < 2; r++) begin
            cyc(1'b1, 0, 1'b0, 1'b0);
            cyc(1'b1, 1, 1'b0, 1'b0);
            cyc(1'b1, 3, 1'b0, 1'b0);
        end
        for (int i = 0; i < 7; i++) cyc(1'b0, 0, 1'b1, 1'b0);

        // Stalled offer on channel 1 while channel 0 fills.
        cyc(1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(i == 1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0);

        // Channel 3 with 7 words, then streaming push+pop across the wrap.
        for (int i = 0; i < 7; i++) cyc(1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 3, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 0, 1'b1, 1'b0);

        // Synchronous clear with two channels loaded and a push pending.
        cyc(1'b1, 1, 1'b0, 1'b0);
        cyc(1'b1, 2, 1'b0, 1'b0);
        cyc(1'b1, 1, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        cyc(1'b1, 0, 1'b0, 1'b0);
        cyc(1'b1, 3, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        push_valid_i = 1'b0;
        rst_ni       = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #2;
        rst_ni = 1'b1;

        // Random traffic with varying drain pressure and rare clears.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                cyc($urandom_range(0, 3) != 0,
                    int'($urandom_range(0, NB_CHAN - 1)),
                    $urandom_range(0, 3) < ph + 1,
                    $urandom_range(0, 299) == 0);
            end
        end

        cyc(1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
